multi_ce_gen: RTL and testbench

Parametrised clock-enable generator that derives up to CHANNELS independent fractional-rate clock enables from one master clock, e.g. 85.909080 MHz. Each channel is a phase accumulator whose increment can be retuned at runtime without glitches. A global sync input phase-aligns the channels. It sits beside the PLL wrapper and replaces its fixed divided outputs (42.95 / 21.48 MHz) with single-clock-domain enables whose ratio and phase are programmable at run time.

---
 rtl/multi_ce_gen_if.sv | 17 +
 rtl/multi_ce_gen.sv | 90 +++++++++
 tb/tb_multi_ce_gen.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/multi_ce_gen_if.sv
// Configuration port of multi_ce_gen: one request carries the target channel,
// its new increment and its phase preset; cfg_ready flags a free pending slot.
interface multi_ce_gen_if #(
  parameter int CHANNELS = 3,
  parameter int ACC_W    = 32
) ();
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic            cfg_valid;
  logic            cfg_ready;
  logic [CH_W-1:0] cfg_ch;
  logic [ACC_W-1:0] cfg_inc;
  logic [ACC_W-1:0] cfg_phase;

  modport master (output cfg_valid, cfg_ch, cfg_inc, cfg_phase, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_inc, cfg_phase, output cfg_ready);
endinterface

// File: rtl/multi_ce_gen.sv
// Multi-channel fractional clock-enable generator: one phase accumulator per
// channel, carry-aligned increment retune, global phase sync, settle-based lock.
module multi_ce_gen #(
  parameter int CHANNELS = 3,
  parameter int ACC_W    = 32,
  parameter int SETTLE   = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  multi_ce_gen_if.slave       cfg,
  input  logic                sync,
  output logic [CHANNELS-1:0] ce_out,
  output logic                locked
);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = $clog2(SETTLE + 1);

  logic [ACC_W-1:0] acc   [CHANNELS];
  logic [ACC_W-1:0] inc   [CHANNELS];
  logic [ACC_W-1:0] phase [CHANNELS];
  logic [ACC_W:0]   sum   [CHANNELS];
  logic [CHANNELS-1:0] carry;
  logic [CHANNELS-1:0] apply;

  logic             pending;
  logic [CH_W-1:0]  pend_ch;
  logic [ACC_W-1:0] pend_inc;
  logic [CNT_W-1:0] cnt;

  logic xfer;
  logic reload;
  logic pend_next;

  assign cfg.cfg_ready = !pending;

  // Out-of-range channels complete the handshake but never occupy the slot.
  assign xfer      = cfg.cfg_valid && !pending && (int'(cfg.cfg_ch) < CHANNELS);
  assign reload    = sync || (|apply);
  assign pend_next = xfer || (pending && !(|apply));

  // A pending increment lands on the channel's carry so no period is cut
  // short; an idle channel (inc 0) has no carry, so it takes it at once.
  always_comb begin
    carry = '0;
    apply = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      sum[i]   = {1'b0, acc[i]} + {1'b0, inc[i]};
      carry[i] = sum[i][ACC_W];
      apply[i] = pending && (pend_ch == CH_W'(i)) && (carry[i] || (inc[i] == '0));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        acc[i]   <= '0;
        inc[i]   <= '0;
        phase[i] <= '0;
      end
      ce_out   <= '0;
      pending  <= 1'b0;
      pend_ch  <= '0;
      pend_inc <= '0;
      cnt      <= CNT_W'(SETTLE);
      locked   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        acc[i]    <= sync ? phase[i] : sum[i][ACC_W-1:0];
        ce_out[i] <= carry[i] && !sync;
        if (apply[i]) inc[i] <= pend_inc;
        if (xfer && (cfg.cfg_ch == CH_W'(i))) phase[i] <= cfg.cfg_phase;
      end

      if (xfer) begin
        pending  <= 1'b1;
        pend_ch  <= cfg.cfg_ch;
        pend_inc <= cfg.cfg_inc;
      end else if (|apply) begin
        pending  <= 1'b0;
      end

      if (reload)          cnt <= CNT_W'(SETTLE);
      else if (cnt != '0)  cnt <= cnt - 1'b1;

      // Registered on the next-state view so lock drops in the transfer cycle
      // and rises exactly SETTLE+1 cycles after the last reload.
      locked <= (cnt == '0) && !reload && !pend_next;
    end
  end
endmodule

// File: tb/tb_multi_ce_gen.sv
// Self-checking bench for multi_ce_gen: cycle scoreboard fed by a behavioural
// model, plus directed period, retune, sync, out-of-range and reset checks.
module tb_multi_ce_gen;
  localparam int  SETTLE = 16;
  localparam longint unsigned M = 64'h1_0000_0000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sync = 1'b0;
  logic [2:0] ce_out;
  logic       locked;

  multi_ce_gen_if #(.CHANNELS(3), .ACC_W(32)) cfg_bus ();

  multi_ce_gen #(.CHANNELS(3), .ACC_W(32), .SETTLE(SETTLE)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cfg    (cfg_bus),
    .sync   (sync),
    .ce_out (ce_out),
    .locked (locked)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural reference: wide arithmetic and an "age since last reload" view of lock.
  longint unsigned m_acc[3], m_inc[3], m_ph[3], m_pinc;
  int  m_pch;
  bit  m_pend;
  int  m_age;

  task automatic model_step();
    logic [2:0] nce;
    bit app_any, xfer;
    longint unsigned s;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin m_acc[i] = 0; m_inc[i] = 0; m_ph[i] = 0; end
      m_pend = 0; m_age = 0; m_pch = 0; m_pinc = 0;
      sb.push_back(32'b0_0010);
    end else begin
      xfer = cfg_bus.cfg_valid && !m_pend && (cfg_bus.cfg_ch < 2'd3);
      app_any = 0;
      nce = '0;
      for (int i = 0; i < 3; i++) begin
        s = m_acc[i] + m_inc[i];
        nce[i] = (s >= M) && !sync;
        if (m_pend && m_pch == i && (s >= M || m_inc[i] == 0)) begin
          m_inc[i] = m_pinc;
          app_any = 1;
        end
        m_acc[i] = sync ? m_ph[i] : (s % M);
      end
      if (app_any) m_pend = 0;
      if (xfer) begin
        m_ph[cfg_bus.cfg_ch] = 64'(cfg_bus.cfg_phase);
        m_pend = 1;
        m_pch  = int'(cfg_bus.cfg_ch);
        m_pinc = 64'(cfg_bus.cfg_inc);
      end
      if (sync || app_any) m_age = 0;
      else if (m_age < 100000) m_age++;
      sb.push_back(32'({nce, !m_pend, (m_age >= SETTLE + 1) && !m_pend}));
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (sb.size() != 0) chk("cycle", 32'({ce_out, cfg_bus.cfg_ready, locked}), sb.pop_front());
  end

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!cfg_bus.cfg_ready && n < 100) begin @(negedge clk); n++; end
    chk(tag, 32'(n < 100), 1);
  endtask

  task automatic wait_locked(input string tag);
    int n = 0;
    while (!locked && n < 200) begin @(negedge clk); n++; end
    chk(tag, 32'(n < 200), 1);
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [31:0] inc, input logic [31:0] ph);
    wait_ready("wr_ready");
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_ch    = ch;
    cfg_bus.cfg_inc   = inc;
    cfg_bus.cfg_phase = ph;
    @(negedge clk);
    cfg_bus.cfg_valid = 1'b0;
  endtask

  task automatic gap(input int ch, output int g);
    int n = 0;
    while (!ce_out[ch] && n < 64) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (!ce_out[ch] && n < 64);
    g = n;
  endtask

  initial begin
    int g, n, cnt, last, mn, mx;
    logic [7:0]  rt_ce, rt_rdy;
    logic [11:0] s_ce0, s_ce1;

    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_ch    = '0;
    cfg_bus.cfg_inc   = '0;
    cfg_bus.cfg_phase = '0;
    repeat (3) @(negedge clk);
    chk("rst_ce", 32'(ce_out), 0);
    chk("rst_ready", 32'(cfg_bus.cfg_ready), 1);
    chk("rst_locked", 32'(locked), 0);
    rst_n = 1'b1;

    // Integer ratios on three channels, then lock delay from the last write.
    cfg_write(2'd0, 32'h8000_0000, 32'h0);
    cfg_write(2'd1, 32'h4000_0000, 32'h0);
    cfg_write(2'd2, 32'h2000_0000, 32'h0);
    wait_ready("ready_ch2");
    n = 0;
    while (!locked && n < 100) begin @(negedge clk); n++; end
    chk("lock_delay", 32'(n), SETTLE + 1);
    for (int r = 0; r < 2; r++) begin
      gap(0, g); chk("gap_ch0", 32'(g), 2);
      gap(1, g); chk("gap_ch1", 32'(g), 4);
      gap(2, g); chk("gap_ch2", 32'(g), 8);
    end

    // Retune ch1 right after one of its pulses: old 4-cycle period must finish.
    wait_locked("lock_pre_rt");
    n = 0;
    while (!ce_out[1] && n < 16) begin @(negedge clk); n++; end
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_ch    = 2'd1;
    cfg_bus.cfg_inc   = 32'h8000_0000;
    cfg_bus.cfg_phase = 32'h0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      cfg_bus.cfg_valid = 1'b0;
      rt_ce[k]  = ce_out[1];
      rt_rdy[k] = cfg_bus.cfg_ready;
      if (k == 0) chk("rt_lock_drop", 32'(locked), 0);
    end
    chk("rt_ce1", 32'(rt_ce), 32'h0000_00A8);
    chk("rt_ready", 32'(rt_rdy), 32'h0000_00F8);

    // Fractional ratio 1/3.
    cfg_write(2'd0, 32'h5555_5555, 32'h0);
    wait_ready("ready_frac");
    cnt = 0; last = -1; mn = 1000; mx = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (ce_out[0]) begin
        cnt++;
        if (last >= 0) begin
          if (k - last < mn) mn = k - last;
          if (k - last > mx) mx = k - last;
        end
        last = k;
      end
    end
    chk("frac_count", 32'(cnt >= 999 && cnt <= 1001), 1);
    chk("frac_min_gap", 32'(mn), 3);
    chk("frac_max_gap", 32'(mx <= 4), 1);

    // Phase presets then sync: ch1 half a turn ahead of ch0.
    cfg_write(2'd0, 32'h4000_0000, 32'h0);
    cfg_write(2'd1, 32'h4000_0000, 32'h8000_0000);
    wait_ready("ready_sync");
    sync = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      sync = 1'b0;
      s_ce0[k] = ce_out[0];
      s_ce1[k] = ce_out[1];
    end
    chk("sync_ce0", 32'(s_ce0), 32'h0000_0110);
    chk("sync_ce1", 32'(s_ce1), 32'h0000_0444);

    // Out-of-range channel: accepted, nothing moves.
    wait_locked("lock_pre_bad");
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_ch    = 2'd3;
    cfg_bus.cfg_inc   = 32'h1234_5678;
    cfg_bus.cfg_phase = 32'h9abc_def0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cfg_bus.cfg_valid = 1'b0;
      chk("bad_ready", 32'(cfg_bus.cfg_ready), 1);
      chk("bad_locked", 32'(locked), 1);
    end

    // Reset while a retune is pending and the settle count is running.
    cfg_write(2'd2, 32'h1000_0000, 32'h0);
    chk("pend_ready", 32'(cfg_bus.cfg_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ce", 32'(ce_out), 0);
    chk("arst_ready", 32'(cfg_bus.cfg_ready), 1);
    chk("arst_locked", 32'(locked), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ce_out != 3'b000) cnt++;
    end
    chk("post_rst_silent", 32'(cnt), 0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
